// File: rtl/fa_bist_pkg.sv
// fa_bist_pkg: shared state encoding and vector constants for the full-adder self-test
package fa_bist_pkg;
  localparam int VEC_W = 3;
  localparam int NUM_VECS = 8;
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECS - 1);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/fa_ref_model.sv
// fa_ref_model: combinational golden full adder, {A,B,C} -> expected sum and carry
module fa_ref_model
  import fa_bist_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             exp_f,
  output logic             exp_ci
);
  // sum is the parity of the inputs; carry is the majority
  always_comb begin
    exp_f  = ^vec;
    exp_ci = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
  end
endmodule

// File: rtl/full_adder_bist.sv
// full_adder_bist: exhaustive self-test engine driving and checking a 1-bit full adder
module full_adder_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_f,
  input  logic       dut_ci,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail_vec
);
  state_t state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic fv_q, fv_d;
  logic [VEC_W-1:0] ffv_q, ffv_d;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic busy_q, busy_d;
  logic exp_f, exp_ci, mismatch;

  fa_ref_model u_ref (
    .vec   (vec_q),
    .exp_f (exp_f),
    .exp_ci(exp_ci)
  );

  assign mismatch = (dut_f != exp_f) | (dut_ci != exp_ci);
  assign {dut_a, dut_b, dut_c} = vec_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_count = err_q;
  assign fail_valid = fv_q;
  assign first_fail_vec = ffv_q;

  // sequencing: apply vector, let the adder settle, check, advance; results held in DONE
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ffv_d   = ffv_q;
    done_d  = done_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = DRIVE;
        vec_d   = '0;
        err_d   = '0;
        fv_d    = 1'b0;
        ffv_d   = '0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        busy_d  = 1'b1;
      end
      DRIVE: begin
        cnt_d   = 4'(SETTLE_CYCLES - 1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 4'd1;
        state_d = (cnt_q == '0) ? CHECK : WAIT;
      end
      CHECK: begin
        err_d = mismatch ? err_q + 4'd1 : err_q;
        fv_d  = fv_q | mismatch;
        ffv_d = (mismatch && !fv_q) ? vec_q : ffv_q;
        if (vec_q == LAST_VEC) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_q == '0) && !mismatch;
        end else begin
          state_d = DRIVE;
          vec_d   = vec_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and result registers; reset aborts any run in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffv_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffv_q   <= ffv_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_full_adder_bist.sv
// tb_full_adder_bist: scoreboard bench for the full-adder self-test engine
module tb_full_adder_bist;
  localparam int LIMIT = 200;

  typedef struct {
    logic [3:0] err;
    logic [2:0] ffv;
    logic       fv;
    logic       pass;
    int         edges;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] start_v = '0;
  logic [2:0] a_v, b_v, c_v, f_v, ci_v, busy_v, done_v, pass_v, fv_v;
  logic [3:0] err_v [3];
  logic [2:0] ffv_v [3];
  int mode = 0;
  logic [5:0] p1 = '0, p4 = '0;
  logic [1:0] ideal0;
  exp_t sb[$];
  logic [2:0] trace[$];
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [1:0] ideal(input logic [2:0] v);
    return {v[2] ^ v[1] ^ v[0], (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])};
  endfunction

  // instance 0: combinational adder with selectable fault; instances 1/2: adder lagging 3 cycles
  assign ideal0 = ideal({a_v[0], b_v[0], c_v[0]});
  assign f_v  = {p4[5], p1[5], ideal0[1] ^ (mode == 2)};
  assign ci_v = {p4[4], p1[4], ideal0[0] & (mode != 1)};

  always @(posedge clk) begin
    p1 <= {p1[3:0], ideal({a_v[1], b_v[1], c_v[1]})};
    p4 <= {p4[3:0], ideal({a_v[2], b_v[2], c_v[2]})};
  end

  full_adder_bist #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .dut_a(a_v[0]), .dut_b(b_v[0]), .dut_c(c_v[0]), .dut_f(f_v[0]), .dut_ci(ci_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
    .fail_valid(fv_v[0]), .first_fail_vec(ffv_v[0]));

  full_adder_bist #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .dut_a(a_v[1]), .dut_b(b_v[1]), .dut_c(c_v[1]), .dut_f(f_v[1]), .dut_ci(ci_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
    .fail_valid(fv_v[1]), .first_fail_vec(ffv_v[1]));

  full_adder_bist #(.SETTLE_CYCLES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .dut_a(a_v[2]), .dut_b(b_v[2]), .dut_c(c_v[2]), .dut_f(f_v[2]), .dut_ci(ci_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
    .fail_valid(fv_v[2]), .first_fail_vec(ffv_v[2]));

  // expected result of a whole run: md 0 good, 1 carry stuck 0, 2 sum inverted, 3 lagging adder
  function automatic exp_t model(input int md, input int s, input logic [2:0] prev);
    exp_t e;
    logic [2:0] v;
    logic [1:0] id, obs;
    e.err = '0; e.fv = 1'b0; e.ffv = '0;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      id = ideal(v);
      case (md)
        0: obs = id;
        1: obs = {id[1], 1'b0};
        2: obs = {~id[1], id[0]};
        default: obs = (s == 1) ? ideal((k == 0) ? prev : v - 3'd1) : id;
      endcase
      if (obs != id) begin
        e.err = e.err + 4'd1;
        if (!e.fv) begin e.fv = 1'b1; e.ffv = v; end
      end
    end
    e.pass = (e.err == 0);
    e.edges = 1 + 8 * (s + 2);
    return e;
  endfunction

  // drive start and count edges until done; edge 1 is the edge that samples start
  task automatic run(input int sel, input int extra, output int edges, output logic done1, output logic busy1);
    edges = 0; done1 = 1'bx; busy1 = 1'bx;
    trace.delete();
    start_v[sel] = 1'b1;
    for (int n = 1; n <= LIMIT; n++) begin
      @(posedge clk); @(negedge clk);
      start_v[sel] = (n + 1 == extra);
      if (n == 1) begin done1 = done_v[sel]; busy1 = busy_v[sel]; end
      trace.push_back({a_v[sel], b_v[sel], c_v[sel]});
      if (done_v[sel]) begin edges = n; break; end
    end
    start_v[sel] = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_v[0], b_v[0], c_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0], fv_v[0], ffv_v[0]} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want all zero",
               {a_v[0], b_v[0], c_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0], fv_v[0], ffv_v[0]});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scenario(input string name, input int sel, input int md, input int extra);
    exp_t e;
    int edges;
    logic d1, b1;
    if (sel == 0) mode = md;
    sb.push_back(model(md, (sel == 0) ? 2 : (sel == 1) ? 1 : 4, 3'd0));
    run(sel, extra, edges, d1, b1);
    e = sb.pop_front();
    n_checks++;
    if (edges !== e.edges) begin
      n_fail++;
      $display("FAIL %s_done_edge: got %0d want %0d", name, edges, e.edges);
    end
    n_checks++;
    if ({b1, d1} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s_busy_after_start: busy,done got %b want 10", name, {b1, d1});
    end
    n_checks++;
    if ({busy_v[sel], pass_v[sel], fv_v[sel], err_v[sel], ffv_v[sel]} !== {1'b0, e.pass, e.fv, e.err, e.ffv}) begin
      n_fail++;
      $display("FAIL %s_result: busy,pass,fv,err,ffv got %b,%b,%b,%0d,%b want 0,%b,%b,%0d,%b", name,
               busy_v[sel], pass_v[sel], fv_v[sel], err_v[sel], ffv_v[sel], e.pass, e.fv, e.err, e.ffv);
    end
  endtask

  task automatic test_good;
    test_scenario("good", 0, 0, 0);
    for (int i = 0; i < 33; i++) begin
      n_checks++;
      if (i >= trace.size() || trace[i] !== ((i < 32) ? 3'(i / 4) : 3'd7)) begin
        n_fail++;
        $display("FAIL good_vector_seq[%0d]: got %b want %b", i,
                 (i < trace.size()) ? trace[i] : 3'bxxx, (i < 32) ? 3'(i / 4) : 3'd7);
      end
    end
  endtask

  task automatic test_ci_stuck;
    test_scenario("ci_stuck", 0, 1, 0);
  endtask

  task automatic test_f_inv;
    test_scenario("f_inv", 0, 2, 0);
  endtask

  task automatic test_lag;
    test_scenario("lag_settle1", 1, 3, 0);
    test_scenario("lag_settle4", 2, 3, 0);
  endtask

  task automatic test_back_to_back;
    test_scenario("start_mid_run", 0, 0, 10);
    test_scenario("restart_from_done", 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    mode = 1;
    start_v[0] = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      @(posedge clk); @(negedge clk);
      start_v[0] = 1'b0;
    end
    n_checks++;
    if ({a_v[0], b_v[0], c_v[0], busy_v[0], fv_v[0]} !== 5'b10111) begin
      n_fail++;
      $display("FAIL midrun_state: vec,busy,fv got %b want 10111", {a_v[0], b_v[0], c_v[0], busy_v[0], fv_v[0]});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_v[0], b_v[0], c_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0], fv_v[0], ffv_v[0]} !== 14'd0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b want all zero",
               {a_v[0], b_v[0], c_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0], fv_v[0], ffv_v[0]});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy_v[0], err_v[0], a_v[0]} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_held: busy,err,a got %b want 0", {busy_v[0], err_v[0], a_v[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_scenario("after_reset", 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_good;
    test_ci_stuck;
    test_f_inv;
    test_lag;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/full_adder_bist.md
Name: full_adder_bist

Overview:
- Hardware self-test engine for the team's 1-bit full adder (inputs A, B, C; outputs F = sum, Ci = carry).
- Drives the adder inputs, waits a settle time, then samples and checks the adder outputs.
- Steps exhaustively through all 8 input vectors and reports pass/fail, an error count and the first failing vector.
- Instantiated beside the full adder on the FPGA board, so the adder can be verified in silicon with no simulator fixture.

Parameters:
- SETTLE_CYCLES, default 2: clock cycles between applying a vector and sampling F/Ci. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a test run; sampled only in IDLE or DONE
- dut_a  out  1  drive to adder input A
- dut_b  out  1  drive to adder input B
- dut_c  out  1  drive to adder input C
- dut_f  in  1  adder sum output
- dut_ci  in  1  adder carry output
- busy  out  1  high while a run is in progress
- done  out  1  high when a run has completed; held until the next start
- pass  out  1  valid while done=1; high only if no mismatch occurred
- err_count  out  4  number of mismatching vectors in the run (0..8)
- fail_valid  out  1  high once any mismatch has been captured
- first_fail_vec  out  3  {A,B,C} of the first mismatching vector

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: dut_a/b/c, busy, done, pass, err_count, fail_valid, first_fail_vec.
  - Internal vector register and settle counter go to 0.
  - Reset asserted mid-run aborts the run immediately; no partial result is retained.
- Vector encoding: vec[2:0] = {A,B,C}, with A as the MSB. dut_a/b/c are driven directly from the registered vec, so there is no glitch between vectors.
- Expected response per vector:
  - exp_f = A^B^C
  - exp_ci = (A&B)|(A&C)|(B&C)
- State IDLE:
  - busy=0.
  - If start=1: vec←0, err_count←0, fail_valid←0, first_fail_vec←0, done←0, pass←0, busy←1; go to DRIVE.
- State DRIVE (1 cycle):
  - Vector is already present on dut_a/b/c.
  - Load settle counter with SETTLE_CYCLES-1; go to WAIT.
- State WAIT (exactly SETTLE_CYCLES cycles):
  - Decrement the counter each cycle.
  - When the counter is 0, go to CHECK.
- State CHECK (1 cycle): compare {dut_f,dut_ci} with {exp_f,exp_ci}.
  - On mismatch: err_count←err_count+1. If fail_valid=0, also first_fail_vec←vec and fail_valid←1.
  - If vec=7: go to DONE. done←1, busy←0, and pass←1 only if there was no mismatch this run, including the current cycle.
  - Otherwise: vec←vec+1 and go to DRIVE.
- State DONE:
  - done, pass, err_count, fail_valid and first_fail_vec hold their values. dut_a/b/c hold 111.
  - start=1 restarts the run exactly as from IDLE, clearing done in the same edge.
- start while busy=1 is ignored; there is no restart mid-run.
- Timing:
  - Each vector occupies SETTLE_CYCLES+2 cycles.
  - done rises 1+8*(SETTLE_CYCLES+2) rising edges after the edge that sampled start. With the default this is 33.
- Width rule: err_count is 4 bits, so the maximum value 8 is representable and no saturation logic is needed.
- State encoding is binary, 3 bits. Unused encodings return to IDLE.

Decomposition:
- Shared package fa_bist_pkg holds:
  - state localparams: IDLE, DRIVE, WAIT, CHECK, DONE;
  - VEC_W=3 and NUM_VECS=8.
- One sub-module, fa_ref_model: purely combinational golden model mapping {A,B,C} → {exp_f, exp_ci}.
  - Reused by the team's other adder checkers.
  - Main module keeps the FSM, counters and capture registers.

Test Plan:
- Good adder connected, SETTLE_CYCLES=2, pulse start → done=1 at edge 33; pass=1, err_count=0, fail_valid=0; dut_a/b/c sequence 000..111, each held 4 cycles.
- Adder model with Ci stuck at 0 → only vectors 011, 101, 110, 111 fail; err_count=4, first_fail_vec=011, fail_valid=1, pass=0.
- Adder model with F inverted → all 8 vectors fail; err_count=8, first_fail_vec=000, pass=0.
- Adder whose output lags 3 cycles, with SETTLE_CYCLES=1 → mismatches reported. Rerun with SETTLE_CYCLES=4 → pass=1.
- start pulsed again at edge 10 of a run → ignored, done still at edge 33. start pulsed in DONE → done drops on the next edge, new run passes.
- rst_n pulled low during WAIT of vector 101 → all outputs are 0 asynchronously (before the next clk edge), state IDLE. A following start gives a complete, clean run.
